// File: rtl/sandbox_pkg.sv
// Shared definitions for the two-copy RIDECORE sandbox: datapath widths,
// the committed-instruction packet, and the ROB age comparison that both
// the commit transmitter and the comparator use to fix up the drain tail.
package sandbox_pkg;

    localparam int DATA_LEN = 32;
    localparam int ROB_SEL  = 6;

    typedef struct packed {
        logic                ismem;
        logic [DATA_LEN-1:0] data;
        logic [ROB_SEL-1:0]  tag;
    } commit_pkt_t;

    // True when the recovery point {hi, tagfix} lies beyond the tracked tail
    // in allocation order, i.e. the mispredict does not squash the tail.
    function automatic logic rob_older(input logic               hi,
                                       input logic [ROB_SEL-1:0] tagfix,
                                       input logic [ROB_SEL-1:0] comptr,
                                       input logic [ROB_SEL-1:0] tail);
        return {hi, tagfix} > {(comptr >= tail), tail};
    endfunction

endpackage

// File: rtl/commit_fifo2.sv
// Circular FIFO with two write ports (written in port order) and one read
// port. The head entry is presented straight from storage; nothing written
// this cycle is visible before the next cycle. Writes that do not fit after
// the same-cycle pop are dropped and flagged.
module commit_fifo2 #(
    parameter  int W     = 39,
    parameter  int DEPTH = 4,
    localparam int LW    = $clog2(DEPTH + 1),
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr0_en,
    input  logic [W-1:0]  wr0_data,
    input  logic          wr1_en,
    input  logic [W-1:0]  wr1_data,
    input  logic          rd_ready,
    output logic          rd_valid,
    output logic [W-1:0]  rd_data,
    output logic [LW-1:0] level,
    output logic [LW-1:0] level_next,
    output logic          overflow
);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wp;
    logic [PW-1:0] rp;
    logic [LW-1:0] level_q;
    logic          pop;
    logic [W-1:0]  first_data;
    int            n_req;
    int            n_free;
    int            n_acc;

    // Work out how many of the offered writes fit and the resulting occupancy.
    always_comb begin
        pop        = (level_q != '0) & rd_ready;
        n_req      = int'(wr0_en) + int'(wr1_en);
        n_free     = DEPTH - int'(level_q) + int'(pop);
        n_acc      = (n_req > n_free) ? n_free : n_req;
        overflow   = (n_req > n_free);
        first_data = wr0_en ? wr0_data : wr1_data;
        level_next = LW'(int'(level_q) + n_acc - int'(pop));
    end

    // Storage and pointer update; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wp      <= '0;
            rp      <= '0;
            level_q <= '0;
        end else begin
            if (n_acc >= 1) mem[wp] <= first_data;
            if (n_acc == 2) mem[wp + PW'(1)] <= wr1_data;
            wp      <= wp + PW'(n_acc);
            rp      <= rp + PW'(pop);
            level_q <= level_next;
        end
    end

    assign rd_valid = (level_q != '0);
    assign rd_data  = mem[rp];
    assign level    = level_q;

endmodule

// File: rtl/commit_trace_tx.sv
// Per-copy commit-stream transmitter. Serialises up to two ROB commits per
// cycle into a one-per-cycle valid/ready stream, requests a clock gate when
// the FIFO is nearly full or the copy has drained, and after a deviation
// tracks the last in-flight instruction so it can report the drain point.
module commit_trace_tx #(
    parameter  int DATA_LEN = sandbox_pkg::DATA_LEN,
    parameter  int ROB_SEL  = sandbox_pkg::ROB_SEL,
    parameter  int DEPTH    = 4,
    localparam int LW       = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                prmiss,
    input  logic                com1_valid,
    input  logic                com2_valid,
    input  logic [ROB_SEL-1:0]  com1_ptr,
    input  logic [ROB_SEL-1:0]  com2_ptr,
    input  logic                com1_ismem,
    input  logic                com2_ismem,
    input  logic [DATA_LEN-1:0] com1_ld_data,
    input  logic [DATA_LEN-1:0] com2_ld_data,
    input  logic [ROB_SEL-1:0]  rrfptr,
    input  logic [ROB_SEL-1:0]  rrftagfix,
    input  logic                rrf_hi,
    input  logic [ROB_SEL-1:0]  rrf_comptr,
    input  logic                freeze,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic                tx_ismem,
    output logic [DATA_LEN-1:0] tx_data,
    output logic [ROB_SEL-1:0]  tx_tag,
    output logic                stall_req,
    output logic                drained,
    output logic                err,
    output logic [LW-1:0]       level
);

    import sandbox_pkg::*;

    localparam int W = 1 + DATA_LEN + ROB_SEL;

    logic               armed_q;
    logic [ROB_SEL-1:0] tail_q;
    logic               drained_q;
    logic               stall_q;
    logic               err_q;

    logic               capture;
    logic [ROB_SEL-1:0] tail_eff;
    logic               acc1;
    logic               acc2;
    logic               hit1;
    logic               hit2;
    logic               bad_pair;
    logic               stall_viol;
    logic               push1;
    logic               push2;
    logic               drained_next;
    logic               stall_next;

    logic [LW-1:0]      level_next;
    logic               fifo_overflow;
    logic [W-1:0]       head;

    // Commit acceptance, tail match and push selection for this cycle.
    always_comb begin
        capture      = freeze & ~armed_q;
        tail_eff     = capture ? (rrfptr - ROB_SEL'(1)) : tail_q;
        bad_pair     = com2_valid & ~com1_valid;
        acc1         = com1_valid & ~prmiss & ~drained_q;
        acc2         = com2_valid & com1_valid & ~prmiss & ~drained_q;
        hit1         = (armed_q | capture) & acc1 & (com1_ptr == tail_eff);
        hit2         = (armed_q | capture) & acc2 & (com2_ptr == tail_eff);
        drained_next = drained_q | hit1 | hit2;
        // The copy's clock is gated while stalled, so anything committed then is lost.
        stall_viol   = stall_q & (acc1 | acc2);
        push1        = acc1 & ~stall_q;
        // Slot 2 is younger than slot 1: once slot 1 is the tail, nothing follows it.
        push2        = acc2 & ~stall_q & ~hit1;
        stall_next   = (int'(level_next) > DEPTH - 2) | drained_next;
    end

    commit_fifo2 #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .wr0_en     (push1),
        .wr0_data   ({com1_ismem, com1_ld_data, com1_ptr}),
        .wr1_en     (push2),
        .wr1_data   ({com2_ismem, com2_ld_data, com2_ptr}),
        .rd_ready   (tx_ready),
        .rd_valid   (tx_valid),
        .rd_data    (head),
        .level      (level),
        .level_next (level_next),
        .overflow   (fifo_overflow)
    );

    // Tail capture/fixup plus the sticky drain, stall and error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed_q   <= 1'b0;
            tail_q    <= '0;
            drained_q <= 1'b0;
            stall_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            if (capture) begin
                armed_q <= 1'b1;
                tail_q  <= tail_eff;
            end else if (armed_q & prmiss) begin
                tail_q <= rob_older(rrf_hi, rrftagfix, rrf_comptr, tail_q)
                          ? tail_q : (rrftagfix - ROB_SEL'(1));
            end
            drained_q <= drained_next;
            stall_q   <= stall_next;
            err_q     <= err_q | bad_pair | stall_viol | fifo_overflow;
        end
    end

    assign {tx_ismem, tx_data, tx_tag} = head;
    assign stall_req = stall_q;
    assign drained   = drained_q;
    assign err       = err_q;

endmodule

// File: tb/tb_commit_trace_tx.sv
// Directed bench for commit_trace_tx (DEPTH=4): stream ordering, stall and
// protocol errors, mispredict masking, tail capture/fixup, drain and async reset.
module tb_commit_trace_tx;

    logic        clk;
    logic        rst;
    logic        prmiss;
    logic        com1_valid, com2_valid;
    logic [5:0]  com1_ptr, com2_ptr;
    logic        com1_ismem, com2_ismem;
    logic [31:0] com1_ld_data, com2_ld_data;
    logic [5:0]  rrfptr, rrftagfix, rrf_comptr;
    logic        rrf_hi;
    logic        freeze;
    logic        tx_valid, tx_ready, tx_ismem;
    logic [31:0] tx_data;
    logic [5:0]  tx_tag;
    logic        stall_req, drained, err;
    logic [2:0]  level;

    int n_assert = 0;
    int n_fail   = 0;

    commit_trace_tx #(.DATA_LEN(32), .ROB_SEL(6), .DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .prmiss       (prmiss),
        .com1_valid   (com1_valid),
        .com2_valid   (com2_valid),
        .com1_ptr     (com1_ptr),
        .com2_ptr     (com2_ptr),
        .com1_ismem   (com1_ismem),
        .com2_ismem   (com2_ismem),
        .com1_ld_data (com1_ld_data),
        .com2_ld_data (com2_ld_data),
        .rrfptr       (rrfptr),
        .rrftagfix    (rrftagfix),
        .rrf_hi       (rrf_hi),
        .rrf_comptr   (rrf_comptr),
        .freeze       (freeze),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .tx_ismem     (tx_ismem),
        .tx_data      (tx_data),
        .tx_tag       (tx_tag),
        .stall_req    (stall_req),
        .drained      (drained),
        .err          (err),
        .level        (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_commits();
        com1_valid = 1'b0;
        com2_valid = 1'b0;
    endtask

    task automatic c1(input logic [5:0] p, input logic m, input logic [31:0] d);
        com1_valid = 1'b1; com1_ptr = p; com1_ismem = m; com1_ld_data = d;
    endtask

    task automatic c2(input logic [5:0] p, input logic m, input logic [31:0] d);
        com2_valid = 1'b1; com2_ptr = p; com2_ismem = m; com2_ld_data = d;
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_tx_valid"}, tx_valid, 0);
        chk({pfx, "_level"}, level, 0);
        chk({pfx, "_stall"}, stall_req, 0);
        chk({pfx, "_drained"}, drained, 0);
        chk({pfx, "_err"}, err, 0);
        chk({pfx, "_tx_tag"}, tx_tag, 0);
        chk({pfx, "_tx_data"}, tx_data, 0);
        chk({pfx, "_tx_ismem"}, tx_ismem, 0);
    endtask

    initial begin
        rst = 1'b1; prmiss = 1'b0; freeze = 1'b0; tx_ready = 1'b0;
        com1_valid = 1'b0; com2_valid = 1'b0;
        com1_ptr = '0; com2_ptr = '0; com1_ismem = 1'b0; com2_ismem = 1'b0;
        com1_ld_data = '0; com2_ld_data = '0;
        rrfptr = '0; rrftagfix = '0; rrf_hi = 1'b0; rrf_comptr = '0;
        #3;
        chk_all_zero("rst");
        step();
        rst = 1'b0;
        step();

        // Two commits in one cycle, consumer always ready
        tx_ready = 1'b1;
        c1(6'd3, 1'b1, 32'hAA);
        c2(6'd4, 1'b0, 32'h55);
        step();
        clear_commits();
        chk("t1_level2", level, 2);
        chk("t1_tag3", tx_tag, 3);
        chk("t1_dataAA", tx_data, 32'hAA);
        chk("t1_ismem1", tx_ismem, 1);
        chk("t1_stall0", stall_req, 0);
        step();
        chk("t1_level1", level, 1);
        chk("t1_tag4", tx_tag, 4);
        chk("t1_data55", tx_data, 32'h55);
        chk("t1_ismem0", tx_ismem, 0);
        step();
        chk("t1_level0", level, 0);
        chk("t1_valid0", tx_valid, 0);
        chk("t1_stall_end", stall_req, 0);

        // Mispredict masks both slots
        prmiss = 1'b1;
        c1(6'd20, 1'b0, 32'h1);
        c2(6'd21, 1'b0, 32'h2);
        step();
        clear_commits();
        prmiss = 1'b0;
        chk("t3_level", level, 0);
        chk("t3_valid", tx_valid, 0);
        chk("t3_err", err, 0);

        // Backpressure: fill to the stall threshold, then commit while stalled
        tx_ready = 1'b0;
        c1(6'd5, 1'b0, 32'h5);
        c2(6'd6, 1'b0, 32'h6);
        step();
        chk("t2_level2", level, 2);
        chk("t2_stall0", stall_req, 0);
        c1(6'd7, 1'b0, 32'h7);
        c2(6'd8, 1'b0, 32'h8);
        step();
        clear_commits();
        chk("t2_level4", level, 4);
        chk("t2_stall1", stall_req, 1);
        chk("t2_head5", tx_tag, 5);
        c1(6'd9, 1'b0, 32'h9);
        step();
        clear_commits();
        chk("t2_err", err, 1);
        chk("t2_level_held", level, 4);
        tx_ready = 1'b1;
        step();
        chk("t2_level3", level, 3);
        chk("t2_stall_at3", stall_req, 1);
        chk("t2_head6", tx_tag, 6);
        step();
        chk("t2_stall_at2", stall_req, 0);
        step();
        step();
        chk("t2_drain_level", level, 0);

        // Freeze captures tail = rrfptr-1 = 9; commits 8,9 drain; 10 is dropped
        freeze = 1'b1;
        rrfptr = 6'd10;
        step();
        chk("t4_cap_drained", drained, 0);
        chk("t4_cap_level", level, 0);
        c1(6'd8, 1'b0, 32'h8);
        c2(6'd9, 1'b1, 32'h9);
        step();
        clear_commits();
        chk("t4_level2", level, 2);
        chk("t4_drained", drained, 1);
        chk("t4_stall", stall_req, 1);
        chk("t4_head8", tx_tag, 8);
        c1(6'd10, 1'b0, 32'h10);
        step();
        clear_commits();
        chk("t4_no_push10", level, 1);
        chk("t4_head9", tx_tag, 9);
        step();
        chk("t4_empty", level, 0);
        chk("t4_drained_sticky", drained, 1);

        // Tail fixup on mispredict: tail 9 -> 6
        freeze = 1'b0;
        rst = 1'b1;
        #1;
        chk("t5_rst_drained", drained, 0);
        #1;
        rst = 1'b0;
        freeze = 1'b1;
        rrfptr = 6'd10;
        step();
        prmiss = 1'b1;
        rrftagfix = 6'd7;
        rrf_hi = 1'b0;
        rrf_comptr = 6'd5;
        step();
        prmiss = 1'b0;
        tx_ready = 1'b0;
        c1(6'd4, 1'b0, 32'h4);
        c2(6'd5, 1'b0, 32'h5);
        step();
        clear_commits();
        chk("t5_level2", level, 2);
        chk("t5_not_drained", drained, 0);
        chk("t5_stall0", stall_req, 0);
        c1(6'd6, 1'b1, 32'h6);
        step();
        clear_commits();
        chk("t5_level3", level, 3);
        chk("t5_drained", drained, 1);
        chk("t5_stall1", stall_req, 1);
        chk("t5_head4", tx_tag, 4);
        chk("t5_err0", err, 0);

        // Asynchronous reset between clock edges
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("t6");
        freeze = 1'b0;
        step();
        rst = 1'b0;

        // Slot 2 without slot 1 is an error and is ignored
        c2(6'd1, 1'b0, 32'h1);
        step();
        clear_commits();
        chk("bad_pair_err", err, 1);
        chk("bad_pair_level", level, 0);

        // Capture cycle that also commits the tail
        freeze = 1'b1;
        rrfptr = 6'd3;
        tx_ready = 1'b1;
        c1(6'd2, 1'b0, 32'h2);
        step();
        clear_commits();
        chk("cap_tail_drained", drained, 1);
        chk("cap_tail_level", level, 1);
        chk("cap_tail_tag", tx_tag, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/commit_trace_tx.md
Name: commit_trace_tx

Overview:
- Per-copy commit-stream transmitter for the two-copy RIDECORE sandbox; one instance sits beside each `topsim` copy.
- Takes the ROB's 0/1/2 commits per cycle and serialises them into a one-entry-per-cycle valid/ready stream toward a decoupled comparator.
- Raises a stall request that the top level uses to gate the copy's clock.
- Tracks the drain tail after a deviation and reports when the copy has committed its last in-flight instruction.

Parameters:
- DATA_LEN, 32, load-data width.
- ROB_SEL, 6, ROB/RRF pointer width.
- DEPTH, 4, FIFO entries; minimum 2, power of two.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- prmiss  in  1  misprediction this cycle; masks all commits.
- com1_valid  in  1  ROB commit slot 1 (commit1).
- com2_valid  in  1  ROB commit slot 2 (commit2).
- com1_ptr, com2_ptr  in  ROB_SEL  comptr / comptr2.
- com1_ismem, com2_ismem  in  1  committing entry is a memory op.
- com1_ld_data, com2_ld_data  in  DATA_LEN  committed load data.
- rrfptr  in  ROB_SEL  rrf_fl.rrfptr (next allocation).
- rrftagfix  in  ROB_SEL  recovery tag on prmiss.
- rrf_hi  in  1  rrf_fl.hi.
- rrf_comptr  in  ROB_SEL  rrf_fl.comptr.
- freeze  in  1  deviation found; level, from comparator.
- tx_valid  out  1  head entry valid.
- tx_ready  in  1  consumer accepts head.
- tx_ismem  out  1  head ismem.
- tx_data  out  DATA_LEN  head load data.
- tx_tag  out  ROB_SEL  head ROB pointer.
- stall_req  out  1  registered; gate copy clock.
- drained  out  1  sticky; tail instruction committed.
- err  out  1  sticky protocol error.
- level  out  $clog2(DEPTH+1)  FIFO occupancy.

Behaviour:

Reset (async)
- FIFO is empty; all outputs are 0, including tx_valid, stall_req, drained and err.
- armed=0, tail=0.

Accept logic
- acc1 = com1_valid & !prmiss & !drained_q.
- acc2 = com2_valid & com1_valid & !prmiss & !drained_q.
- com2_valid without com1_valid: err<=1, and slot 2 is ignored.
- Push order: slot 1, then slot 2 (0, 1 or 2 pushes per cycle).
- After the drain hit, commits beyond tail are never pushed: pushes of the current cycle stop after the entry whose ptr==tail_eff.

FIFO
- Circular, with head/tail pointers wrapping modulo DEPTH.
- Outputs are driven from head storage. tx_valid = (level != 0).
- Pop when tx_valid & tx_ready.
- Push and pop in the same cycle are legal.
- Latency: a pushed entry is visible on tx_* the next cycle; there is no bypass.
- level_next = level + pushes - pop.
- Overflow (pushes exceed free slots after pop): excess entries are dropped and err<=1.

Stall
- stall_req <= (DEPTH - level_next < 2) | drained_next.
- While stall_req=1 the clock is gated, so any commit seen then is a protocol violation: err<=1 and the entry is dropped.

Tail tracking
- First cycle with freeze=1 and armed=0: tail_eff = rrfptr - 1 (mod 2^ROB_SEL), armed<=1.
- Otherwise tail_eff = tail.
- When armed & prmiss: tail <= ({rrf_hi, rrftagfix} > {rrf_comptr >= tail, tail}) ? tail : rrftagfix - 1. The comparison is unsigned, ROB_SEL+1 bits.
- freeze deasserting does not disarm.

Drain
- drained <= 1 when (armed | capture) & !prmiss & ((acc1 & com1_ptr==tail_eff) | (acc2 & com2_ptr==tail_eff)).
- drained is cleared only by reset.
- FIFO contents continue to drain to the consumer after drained is set.

Simultaneous events
- A capture cycle that also commits the tail compares against the just-captured tail_eff.
- prmiss in a capture cycle: capture still happens, and the fix applies from the next prmiss.

Decomposition:
- Shared package `sandbox_pkg`:
  - DATA_LEN / ROB_SEL constants, taken from define.v values.
  - `commit_pkt_t` struct {ismem, data, tag}.
  - Function `rob_older(hi, tagfix, comptr, tail)` implementing the tail-fix comparison, so the comparator reuses it.
- One sub-module, `commit_fifo2`: a 2-write/1-read FIFO with level output; tail/drain logic stays in the top.

Test Plan:
1. DEPTH=4, tx_ready=1, a 2-commit cycle (ptr 3, ismem=1, data 0xAA; ptr 4, ismem=0) → tx_tag=3 (tx_data=0xAA) the next cycle, then tag 4; level 2→1→0; stall_req stays 0.
2. tx_ready=0, two 2-commit cycles → level=2 then stall_req=1 when level reaches 3 or 4 (free<2); a commit injected while stall_req=1 → err=1, level unchanged.
3. prmiss=1 with com1_valid=com2_valid=1 → no push, level unchanged, err=0.
4. freeze rises with rrfptr=10 (tail=9); next cycle slot1 ptr 8, slot2 ptr 9 → both pushed, drained=1, stall_req=1; a later commit of ptr 10 → not pushed.
5. Armed tail=9, prmiss with rrftagfix=7, rrf_hi=0, rrf_comptr=5 → tail=6; commit ptr 6 → drained=1.
6. Assert rst mid-stream with level=3 and drained=1 → all outputs 0 immediately, without waiting for a clock edge.
